// File: rtl/bcd_rtc_core.sv
// BCD real-time-clock core: subsecond prescaler, sec..year carry chain with 12/24h and leap phase, latched read shadow.
// Latency: field writes and latch land one cycle after the strobe; a tick colliding with a write is applied one cycle later.
// Backpressure: none; every strobe is accepted in the cycle it is asserted.
module bcd_rtc_core #(
    parameter int TICKS_PER_SEC = 4194304,
    parameter int SUBSEC_W      = 22,
    parameter int SPEED_SHIFT   = 0
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       halt,
    input  logic       wr_en,
    input  logic [2:0] wr_field,
    input  logic [7:0] wr_data,
    input  logic       latch,
    input  logic [2:0] rd_field,
    output logic [7:0] rd_data,
    output logic       sec_pulse,
    output logic       day_pulse
);
    localparam logic [SUBSEC_W:0] TPS  = (SUBSEC_W+1)'(TICKS_PER_SEC);
    localparam logic [SUBSEC_W:0] STEP = (SUBSEC_W+1)'(1) << SPEED_SHIFT;

    logic [SUBSEC_W-1:0] subsec_q, subsec_d;
    logic [SUBSEC_W:0]   sum;
    logic                pending_q, pending_d;
    logic [7:0]          sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic [7:0]          day_q, day_d, month_q, month_d, year_q, year_d;
    logic [2:0]          wday_q, wday_d;
    logic [1:0]          leap_q, leap_d;
    logic                mode_24h_q, mode_24h_d;
    logic [7:0]          sh_sec_q, sh_sec_d, sh_min_q, sh_min_d, sh_hour_q, sh_hour_d;
    logic [7:0]          sh_day_q, sh_day_d, sh_month_q, sh_month_d, sh_year_q, sh_year_d;
    logic [2:0]          sh_wday_q, sh_wday_d, sh_ctrl_q, sh_ctrl_d;
    logic                sec_pulse_q, sec_pulse_d, day_pulse_q, day_pulse_d;
    logic                new_tick, apply_tick;
    logic                c_min, c_hour, c_day, c_month, c_year;
    logic [7:0]          dim;

    // Decade increment: an out-of-range low digit simply wraps F -> 0 with no carry.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
        return {v[7:4], v[3:0] + 4'h1};
    endfunction

    always_comb begin
        subsec_d   = subsec_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_d      = day_q;
        month_d    = month_q;
        year_d     = year_q;
        wday_d     = wday_q;
        leap_d     = leap_q;
        mode_24h_d = mode_24h_q;
        c_min      = 1'b0;
        c_hour     = 1'b0;
        c_day      = 1'b0;
        c_month    = 1'b0;
        c_year     = 1'b0;
        new_tick   = 1'b0;

        sum = {1'b0, subsec_q} + STEP;
        if (ce && !halt) begin
            if (sum >= TPS) begin
                sum      = sum - TPS;
                new_tick = 1'b1;
            end
            subsec_d = sum[SUBSEC_W-1:0];
        end

        // A tick landing on a write cycle waits one cycle so it acts on the written value.
        apply_tick = !wr_en && (pending_q || new_tick);
        if (wr_en) pending_d = (wr_field == 3'd0) ? 1'b0 : (pending_q || new_tick);
        else       pending_d = pending_q && new_tick;

        case (month_q)
            8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
            8'h02:                      dim = (leap_q == 2'd0) ? 8'h29 : 8'h28;
            default:                    dim = 8'h31;
        endcase

        if (apply_tick) begin
            if (sec_q == 8'h59) begin sec_d = 8'h00; c_min = 1'b1; end
            else sec_d = bcd_inc(sec_q);
        end
        if (c_min) begin
            if (min_q == 8'h59) begin min_d = 8'h00; c_hour = 1'b1; end
            else min_d = bcd_inc(min_q);
        end
        if (c_hour) begin
            if (mode_24h_q) begin
                if (hour_q == 8'h23) begin hour_d = 8'h00; c_day = 1'b1; end
                else hour_d = bcd_inc(hour_q);
            end else begin
                // hour[5] is the PM flag; the meridiem flips on 11 -> 12, day rolls only at PM 11.
                case (hour_q[4:0])
                    5'h11: begin
                        hour_d = {hour_q[7:6], ~hour_q[5], 5'h12};
                        c_day  = hour_q[5];
                    end
                    5'h12:   hour_d = {hour_q[7:5], 5'h01};
                    default: hour_d = bcd_inc(hour_q);
                endcase
            end
        end
        if (c_day) begin
            wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
            if (day_q == dim) begin day_d = 8'h01; c_month = 1'b1; end
            else day_d = bcd_inc(day_q);
        end
        if (c_month) begin
            if (month_q == 8'h12) begin
                month_d = 8'h01;
                c_year  = 1'b1;
                leap_d  = leap_q + 2'd1;
            end else month_d = bcd_inc(month_q);
        end
        if (c_year) year_d = (year_q == 8'h99) ? 8'h00 : bcd_inc(year_q);

        if (wr_en) begin
            case (wr_field)
                3'd0: begin sec_d = wr_data; subsec_d = '0; end
                3'd1: min_d   = wr_data;
                3'd2: hour_d  = wr_data;
                3'd3: day_d   = wr_data;
                3'd4: month_d = wr_data;
                3'd5: year_d  = wr_data;
                3'd6: wday_d  = wr_data[2:0];
                default: begin
                    mode_24h_d = wr_data[0];
                    leap_d     = wr_data[2:1];
                end
            endcase
        end

        sh_sec_d   = sh_sec_q;
        sh_min_d   = sh_min_q;
        sh_hour_d  = sh_hour_q;
        sh_day_d   = sh_day_q;
        sh_month_d = sh_month_q;
        sh_year_d  = sh_year_q;
        sh_wday_d  = sh_wday_q;
        sh_ctrl_d  = sh_ctrl_q;
        if (latch) begin
            sh_sec_d   = sec_d;
            sh_min_d   = min_d;
            sh_hour_d  = hour_d;
            sh_day_d   = day_d;
            sh_month_d = month_d;
            sh_year_d  = year_d;
            sh_wday_d  = wday_d;
            sh_ctrl_d  = {leap_d, mode_24h_d};
        end

        sec_pulse_d = apply_tick;
        day_pulse_d = c_day;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            subsec_q    <= '0;
            pending_q   <= 1'b0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            day_q       <= 8'h01;
            month_q     <= 8'h01;
            year_q      <= 8'h00;
            wday_q      <= 3'd0;
            leap_q      <= 2'd0;
            mode_24h_q  <= 1'b1;
            sh_sec_q    <= 8'h00;
            sh_min_q    <= 8'h00;
            sh_hour_q   <= 8'h00;
            sh_day_q    <= 8'h00;
            sh_month_q  <= 8'h00;
            sh_year_q   <= 8'h00;
            sh_wday_q   <= 3'd0;
            sh_ctrl_q   <= 3'd0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
        end else begin
            subsec_q    <= subsec_d;
            pending_q   <= pending_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            wday_q      <= wday_d;
            leap_q      <= leap_d;
            mode_24h_q  <= mode_24h_d;
            sh_sec_q    <= sh_sec_d;
            sh_min_q    <= sh_min_d;
            sh_hour_q   <= sh_hour_d;
            sh_day_q    <= sh_day_d;
            sh_month_q  <= sh_month_d;
            sh_year_q   <= sh_year_d;
            sh_wday_q   <= sh_wday_d;
            sh_ctrl_q   <= sh_ctrl_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
        end
    end

    always_comb begin
        case (rd_field)
            3'd0:    rd_data = sh_sec_q;
            3'd1:    rd_data = sh_min_q;
            3'd2:    rd_data = sh_hour_q;
            3'd3:    rd_data = sh_day_q;
            3'd4:    rd_data = sh_month_q;
            3'd5:    rd_data = sh_year_q;
            3'd6:    rd_data = {5'b0, sh_wday_q};
            default: rd_data = {5'b0, sh_ctrl_q};
        endcase
    end

    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
endmodule

// File: tb/tb_bcd_rtc_core.sv
// Directed bench for bcd_rtc_core at four ce per second; expected values are hand-derived BCD constants.
module tb_bcd_rtc_core;
    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       halt = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_field = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       latch = 1'b0;
    logic [2:0] rd_field = 3'd0;
    logic [7:0] rd_data;
    logic       sec_pulse, day_pulse;
    int         n_chk = 0;
    int         n_pass = 0;
    int         halt_pulses = 0;

    bcd_rtc_core #(.TICKS_PER_SEC(4), .SUBSEC_W(3), .SPEED_SHIFT(0)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .halt(halt),
        .wr_en(wr_en), .wr_field(wr_field), .wr_data(wr_data),
        .latch(latch), .rd_field(rd_field), .rd_data(rd_data),
        .sec_pulse(sec_pulse), .day_pulse(day_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk_sys); #1;
    endtask

    task automatic wr(input logic [2:0] f, input logic [7:0] d);
        wr_en = 1'b1; wr_field = f; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic ce_n(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1;
            cyc();
            ce = 1'b0;
        end
    endtask

    task automatic do_latch();
        latch = 1'b1;
        cyc();
        latch = 1'b0;
    endtask

    task automatic rd(input logic [2:0] f, input logic [7:0] exp, input string tag);
        rd_field = f;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        wr(3'd2, h);
        wr(3'd1, m);
        wr(3'd0, s);
    endtask

    initial begin
        repeat (2) cyc();
        for (int f = 0; f < 8; f++) rd(3'(f), 8'h00, "reset_shadow");
        chk("reset_sec_pulse", {7'b0, sec_pulse}, 8'h00);
        chk("reset_day_pulse", {7'b0, day_pulse}, 8'h00);
        reset = 1'b0;
        cyc();
        do_latch();
        rd(3'd3, 8'h01, "reset_day");
        rd(3'd4, 8'h01, "reset_month");
        rd(3'd7, 8'h01, "reset_ctrl");

        // 23:59:59 in 24h mode rolls the day
        set_time(8'h23, 8'h59, 8'h59);
        ce_n(3);
        chk("no_tick_after_3ce", {7'b0, sec_pulse}, 8'h00);
        ce_n(1);
        chk("tick_sec_pulse", {7'b0, sec_pulse}, 8'h01);
        chk("tick_day_pulse", {7'b0, day_pulse}, 8'h01);
        cyc();
        chk("day_pulse_one_cycle", {7'b0, day_pulse}, 8'h00);
        do_latch();
        rd(3'd0, 8'h00, "h24_sec");
        rd(3'd1, 8'h00, "h24_min");
        rd(3'd2, 8'h00, "h24_hour");
        rd(3'd3, 8'h02, "h24_day");
        rd(3'd6, 8'h01, "h24_wday");

        // 12h: PM 11:59:59 -> AM 12 with day carry
        wr(3'd7, 8'h00);
        set_time(8'h31, 8'h59, 8'h59);
        ce_n(4);
        chk("pm11_day_pulse", {7'b0, day_pulse}, 8'h01);
        do_latch();
        rd(3'd2, 8'h12, "pm11_hour");
        rd(3'd3, 8'h03, "pm11_day");
        rd(3'd6, 8'h02, "pm11_wday");
        rd(3'd7, 8'h00, "pm11_ctrl");

        // 12h: AM 11:59:59 -> PM 12, no day carry
        set_time(8'h11, 8'h59, 8'h59);
        ce_n(4);
        chk("am11_sec_pulse", {7'b0, sec_pulse}, 8'h01);
        chk("am11_day_pulse", {7'b0, day_pulse}, 8'h00);
        do_latch();
        rd(3'd2, 8'h32, "am11_hour");
        rd(3'd3, 8'h03, "am11_day");

        // Leap phase 1: Feb has 28 days
        wr(3'd7, 8'h03);
        wr(3'd4, 8'h02);
        wr(3'd3, 8'h28);
        set_time(8'h23, 8'h59, 8'h59);
        ce_n(4);
        do_latch();
        rd(3'd4, 8'h03, "leap1_month");
        rd(3'd3, 8'h01, "leap1_day");

        // Leap phase 0: Feb 29 exists
        wr(3'd7, 8'h01);
        wr(3'd4, 8'h02);
        wr(3'd3, 8'h28);
        set_time(8'h23, 8'h59, 8'h59);
        ce_n(4);
        do_latch();
        rd(3'd4, 8'h02, "leap0_month");
        rd(3'd3, 8'h29, "leap0_day");
        set_time(8'h23, 8'h59, 8'h59);
        ce_n(4);
        do_latch();
        rd(3'd4, 8'h03, "leap0_next_month");
        rd(3'd3, 8'h01, "leap0_next_day");
        rd(3'd6, 8'h05, "leap0_wday");

        // New year: 12/31/99 23:59:59, leap 3 -> 01/01/00, leap 0
        wr(3'd7, 8'h07);
        wr(3'd4, 8'h12);
        wr(3'd3, 8'h31);
        wr(3'd5, 8'h99);
        set_time(8'h23, 8'h59, 8'h59);
        ce_n(4);
        do_latch();
        rd(3'd4, 8'h01, "ny_month");
        rd(3'd3, 8'h01, "ny_day");
        rd(3'd5, 8'h00, "ny_year");
        rd(3'd7, 8'h01, "ny_ctrl");
        rd(3'd6, 8'h06, "ny_wday");

        // Weekday wraps 6 -> 0
        set_time(8'h23, 8'h59, 8'h59);
        ce_n(4);
        do_latch();
        rd(3'd6, 8'h00, "wday_wrap");
        rd(3'd3, 8'h02, "wday_wrap_day");

        // Tick colliding with a min write is deferred one cycle
        wr(3'd0, 8'h59);
        ce_n(3);
        ce = 1'b1; wr_en = 1'b1; wr_field = 3'd1; wr_data = 8'h42;
        cyc();
        ce = 1'b0; wr_en = 1'b0;
        chk("collide_no_pulse_yet", {7'b0, sec_pulse}, 8'h00);
        cyc();
        chk("collide_deferred_pulse", {7'b0, sec_pulse}, 8'h01);
        do_latch();
        rd(3'd1, 8'h43, "collide_min");
        rd(3'd0, 8'h00, "collide_sec");

        // Halt freezes counting
        halt = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ce = 1'b1;
            cyc();
            ce = 1'b0;
            if (sec_pulse) halt_pulses++;
        end
        halt = 1'b0;
        chk("halt_pulses", 8'(halt_pulses), 8'h00);
        do_latch();
        rd(3'd0, 8'h00, "halt_sec");
        rd(3'd1, 8'h43, "halt_min");

        // Sec write clears the subsecond phase
        ce_n(2);
        wr(3'd0, 8'h30);
        ce_n(3);
        chk("subsec_clear_no_pulse", {7'b0, sec_pulse}, 8'h00);
        do_latch();
        rd(3'd0, 8'h30, "subsec_clear_sec");
        ce_n(1);
        chk("subsec_clear_pulse", {7'b0, sec_pulse}, 8'h01);

        // Latch coincident with a tick captures the new second
        ce_n(3);
        ce = 1'b1; latch = 1'b1;
        cyc();
        ce = 1'b0; latch = 1'b0;
        rd(3'd0, 8'h32, "latch_with_tick");

        // Reset mid-operation drops a pending tick
        wr(3'd0, 8'h10);
        ce_n(3);
        ce = 1'b1; wr_en = 1'b1; wr_field = 3'd1; wr_data = 8'h05;
        cyc();
        ce = 1'b0; wr_en = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midreset_sec_pulse", {7'b0, sec_pulse}, 8'h00);
        cyc();
        chk("midreset_pending_dropped", {7'b0, sec_pulse}, 8'h00);
        rd(3'd0, 8'h00, "midreset_shadow");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
